// File: rtl/vtregs_ext_if.sv
// Wishbone slave bus bundle for the video-controller register block.
// Clock and reset travel as plain ports alongside it.
interface vtregs_ext_if;
   logic [15:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [1:0]  wb_sel_i;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/vtregs_ext.sv
// Terminal video-controller registers: cursor, VTCSR, display start, status,
// plus frame-driven blink phase, self-timing beep, frame counter and frame irq.
module vtregs_ext #(
   parameter int CURW         = 11,
   parameter int SAW          = 11,
   parameter int BLINK_FRAMES = 16,
   parameter int BEEP_FRAMES  = 10
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   vtregs_ext_if.slave     bus,
   input  logic [2:0]      initspeed,
   input  logic            frame_i,
   output logic [CURW-1:0] cursor,
   output logic [15:0]     vtcsr,
   output logic [SAW-1:0]  vstart,
   output logic            irq_o
);
   localparam int BLW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int BPW = $clog2(BEEP_FRAMES + 1);
   localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_FRAMES - 1);
   localparam logic [BPW-1:0] BEEP_LOAD  = BPW'(BEEP_FRAMES);

   logic [CURW-1:0] cursor_reg, cursor_next;
   logic [SAW-1:0]  vstart_reg, vstart_next;
   logic [9:0]      csr_hi_reg, csr_hi_next;   // VTCSR[15:6]
   logic [3:0]      csr_lo_reg, csr_lo_next;   // VTCSR[3:0]
   logic            beep_reg, beep_next;
   logic            blink_reg, blink_next;
   logic [BLW-1:0]  blink_cnt_reg, blink_cnt_next;
   logic [BPW-1:0]  beep_cnt_reg, beep_cnt_next;
   logic            flag_reg, flag_next;
   logic [7:0]      frame_cnt_reg, frame_cnt_next;
   logic            ack_reg;
   logic [15:0]     dat_o_reg, dat_o_next;

   logic        reply, wr_en, rd_en;
   logic [1:0]  reg_sel;
   logic [15:0] wmask;
   logic [15:0] rd_mux;
   logic        unused_bits;

   assign reply   = bus.wb_cyc_i & bus.wb_stb_i & ~ack_reg;
   assign wr_en   = reply & bus.wb_we_i;
   assign rd_en   = reply & ~bus.wb_we_i;
   assign reg_sel = bus.wb_adr_i[2:1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign wmask[gi*8 +: 8] = {8{bus.wb_sel_i[gi]}};
      end
   endgenerate

   assign unused_bits = ^{bus.wb_adr_i[15:3], bus.wb_adr_i[0], wmask[5], bus.wb_dat_i[5]};

   assign cursor = cursor_reg;
   assign vstart = vstart_reg;
   assign vtcsr  = {csr_hi_reg, blink_reg, beep_reg, csr_lo_reg};
   assign irq_o  = flag_reg & csr_hi_reg[0];

   assign bus.wb_ack_o = ack_reg;
   assign bus.wb_dat_o = dat_o_reg;

   always_comb begin
      rd_mux = 16'h0000;
      case (reg_sel)
         2'd0: rd_mux = 16'(cursor_reg);
         2'd1: rd_mux = vtcsr;
         2'd2: rd_mux = 16'(vstart_reg);
         2'd3: rd_mux = {frame_cnt_reg, 7'b0, flag_reg};
         default: rd_mux = 16'h0000;
      endcase
   end

   always_comb begin
      cursor_next    = cursor_reg;
      vstart_next    = vstart_reg;
      csr_hi_next    = csr_hi_reg;
      csr_lo_next    = csr_lo_reg;
      beep_next      = beep_reg;
      blink_next     = blink_reg;
      blink_cnt_next = blink_cnt_reg;
      beep_cnt_next  = beep_cnt_reg;
      flag_next      = flag_reg;
      frame_cnt_next = frame_cnt_reg;
      dat_o_next     = dat_o_reg;

      if (rd_en) begin
         dat_o_next = rd_mux;
      end

      // Blink phase and its counter are owned by frame_i alone.
      if (frame_i) begin
         frame_cnt_next = frame_cnt_reg + 8'd1;
         if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_next     = ~blink_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
         end
      end

      if (frame_i && beep_cnt_reg != '0) begin
         beep_cnt_next = beep_cnt_reg - 1'b1;
         if (beep_cnt_reg == BPW'(1)) begin
            beep_next = 1'b0;
         end
      end

      if (wr_en) begin
         case (reg_sel)
            2'd0: cursor_next = (cursor_reg & ~wmask[CURW-1:0]) |
                                (bus.wb_dat_i[CURW-1:0] & wmask[CURW-1:0]);
            2'd1: begin
               csr_hi_next = (csr_hi_reg & ~wmask[15:6]) | (bus.wb_dat_i[15:6] & wmask[15:6]);
               csr_lo_next = (csr_lo_reg & ~wmask[3:0]) | (bus.wb_dat_i[3:0] & wmask[3:0]);
               // A low-byte write to D4 overrides any same-cycle decrement.
               if (wmask[4]) begin
                  if (bus.wb_dat_i[4]) begin
                     beep_next     = 1'b1;
                     beep_cnt_next = BEEP_LOAD;
                  end else begin
                     beep_next     = 1'b0;
                     beep_cnt_next = '0;
                  end
               end
            end
            2'd2: vstart_next = (vstart_reg & ~wmask[SAW-1:0]) |
                                (bus.wb_dat_i[SAW-1:0] & wmask[SAW-1:0]);
            2'd3: begin
               if (bus.wb_sel_i[0] && bus.wb_dat_i[0]) begin
                  flag_next = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // A new frame beats a coincident clear.
      if (frame_i) begin
         flag_next = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cursor_reg    <= '0;
         vstart_reg    <= '0;
         csr_hi_reg    <= {5'b0, initspeed, 2'b00};
         csr_lo_reg    <= 4'h1;
         beep_reg      <= 1'b0;
         blink_reg     <= 1'b0;
         blink_cnt_reg <= '0;
         beep_cnt_reg  <= '0;
         flag_reg      <= 1'b0;
         frame_cnt_reg <= 8'h00;
         ack_reg       <= 1'b0;
         dat_o_reg     <= 16'h0000;
      end else begin
         cursor_reg    <= cursor_next;
         vstart_reg    <= vstart_next;
         csr_hi_reg    <= csr_hi_next;
         csr_lo_reg    <= csr_lo_next;
         beep_reg      <= beep_next;
         blink_reg     <= blink_next;
         blink_cnt_reg <= blink_cnt_next;
         beep_cnt_reg  <= beep_cnt_next;
         flag_reg      <= flag_next;
         frame_cnt_reg <= frame_cnt_next;
         ack_reg       <= reply;
         dat_o_reg     <= dat_o_next;
      end
   end
endmodule

// File: tb/tb_vtregs_ext.sv
// Self-checking bench for vtregs_ext: directed table, hand sequences for
// blink/beep/reset corners, then random traffic against a frame-level model.
module tb_vtregs_ext;
   localparam int CURW  = 11;
   localparam int SAW   = 11;
   localparam int BLINK = 4;
   localparam int BEEP  = 3;
   localparam logic [15:0] CUR_MASK = 16'((32'd1 << CURW) - 1);
   localparam logic [15:0] SA_MASK  = 16'((32'd1 << SAW) - 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] initspeed = 3'b100;
   logic frame = 1'b0;
   logic [CURW-1:0] cursor;
   logic [15:0] vtcsr;
   logic [SAW-1:0] vstart;
   logic irq;

   vtregs_ext_if bus();

   vtregs_ext #(.CURW(CURW), .SAW(SAW), .BLINK_FRAMES(BLINK), .BEEP_FRAMES(BEEP)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .bus      (bus),
      .initspeed(initspeed),
      .frame_i  (frame),
      .cursor   (cursor),
      .vtcsr    (vtcsr),
      .vstart   (vstart),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, kept at register-map level.
   logic [15:0] m_cursor, m_csr, m_vstart;
   logic        m_flag;
   int          m_fcnt, m_blink_frames, m_beep_left;

   typedef struct {
      int          op;      // 0 read, 1 write, 2 frame only
      logic [1:0]  adr;
      logic [15:0] dat;
      logic [1:0]  sel;
      logic        frm;
      logic [15:0] exp_rd;
      logic        exp_irq;
   } row_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cursor = 0; m_vstart = 0;
      m_csr = {5'b0, initspeed, 8'h01};
      m_flag = 0; m_fcnt = 0; m_blink_frames = 0; m_beep_left = 0;
   endtask

   function automatic logic [15:0] model_read(input logic [1:0] adr);
      logic [7:0] fc;
      fc = 8'(m_fcnt);
      case (adr)
         2'd0: return m_cursor;
         2'd1: return m_csr;
         2'd2: return m_vstart;
         default: return {fc, 7'b0, m_flag};
      endcase
   endfunction

   task automatic model_step(input int op, input logic [1:0] adr, input logic [15:0] dat,
                             input logic [1:0] sel, input logic frm);
      logic [15:0] wm, keep;
      bit loaded, clr;
      wm = {{8{sel[1]}}, {8{sel[0]}}};
      keep = 16'h0030;
      loaded = 0; clr = 0;
      if (op == 1) begin
         case (adr)
            2'd0: m_cursor = ((m_cursor & ~wm) | (dat & wm)) & CUR_MASK;
            2'd1: begin
               m_csr = (m_csr & (~wm | keep)) | (dat & wm & ~keep);
               if (sel[0]) begin
                  loaded = 1;
                  m_beep_left = dat[4] ? BEEP : 0;
                  m_csr[4] = dat[4];
               end
            end
            2'd2: m_vstart = ((m_vstart & ~wm) | (dat & wm)) & SA_MASK;
            default: clr = sel[0] & dat[0];
         endcase
      end
      if (clr) m_flag = 0;
      if (frm) begin
         m_flag = 1;
         m_fcnt = (m_fcnt + 1) % 256;
         m_blink_frames++;
         if (m_blink_frames == BLINK) begin
            m_blink_frames = 0;
            m_csr[5] = ~m_csr[5];
         end
         if (!loaded && m_beep_left > 0) begin
            m_beep_left--;
            if (m_beep_left == 0) m_csr[4] = 0;
         end
      end
   endtask

   task automatic txn(input int op, input logic [1:0] adr, input logic [15:0] dat,
                      input logic [1:0] sel, input logic frm, output logic [15:0] rd);
      logic [15:0] exp_rd;
      @(negedge clk);
      if (op != 2) begin
         check("ack_idle", 32'(bus.wb_ack_o), 32'd0);
         bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = (op == 1);
         bus.wb_adr_i = {13'b0, adr, 1'b0}; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
      end
      frame = frm;
      exp_rd = model_read(adr);
      @(posedge clk); #1;
      model_step(op, adr, dat, sel, frm);
      rd = bus.wb_dat_o;
      if (op != 2) check("ack_hi", 32'(bus.wb_ack_o), 32'd1);
      if (op == 0) check("rd_model", 32'(rd), 32'(exp_rd));
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; frame = 0;
      @(posedge clk); #1;
      if (op != 2) check("ack_lo", 32'(bus.wb_ack_o), 32'd0);
      check("cursor", 32'(cursor), 32'(m_cursor));
      check("vtcsr", 32'(vtcsr), 32'(m_csr));
      check("vstart", 32'(vstart), 32'(m_vstart));
      check("irq", 32'(irq), 32'(m_flag & m_csr[6]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; frame = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   row_t tbl[18];
   logic [15:0] rd;
   int acks;

   initial begin
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;

      tbl[0]  = '{0, 2'd1, 16'h0000, 2'b11, 1'b0, 16'h0401, 1'b0};
      tbl[1]  = '{0, 2'd0, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b0};
      tbl[2]  = '{0, 2'd2, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b0};
      tbl[3]  = '{0, 2'd3, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b0};
      tbl[4]  = '{1, 2'd0, 16'hFFFF, 2'b01, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{0, 2'd0, 16'h0000, 2'b11, 1'b0, 16'h00FF, 1'b0};
      tbl[6]  = '{1, 2'd0, 16'hFFFF, 2'b10, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{0, 2'd0, 16'h0000, 2'b11, 1'b0, 16'h07FF, 1'b0};
      tbl[8]  = '{1, 2'd2, 16'hABCD, 2'b11, 1'b0, 16'h0000, 1'b0};
      tbl[9]  = '{0, 2'd2, 16'h0000, 2'b11, 1'b0, 16'h03CD, 1'b0};
      tbl[10] = '{1, 2'd1, 16'h0445, 2'b11, 1'b0, 16'h0000, 1'b0};
      tbl[11] = '{0, 2'd1, 16'h0000, 2'b11, 1'b0, 16'h0445, 1'b0};
      tbl[12] = '{2, 2'd0, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1};
      tbl[13] = '{0, 2'd3, 16'h0000, 2'b11, 1'b0, 16'h0101, 1'b1};
      tbl[14] = '{1, 2'd3, 16'h0001, 2'b01, 1'b1, 16'h0000, 1'b1};
      tbl[15] = '{0, 2'd3, 16'h0000, 2'b11, 1'b0, 16'h0201, 1'b1};
      tbl[16] = '{1, 2'd3, 16'h0001, 2'b01, 1'b0, 16'h0000, 1'b0};
      tbl[17] = '{0, 2'd3, 16'h0000, 2'b11, 1'b0, 16'h0200, 1'b0};

      do_reset();
      @(posedge clk); #1;
      check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_vtcsr", 32'(vtcsr), 32'h0401);

      foreach (tbl[i]) begin
         txn(tbl[i].op, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].frm, rd);
         if (tbl[i].op == 0) check($sformatf("tbl%0d_rd", i), 32'(rd), 32'(tbl[i].exp_rd));
         check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
         $display("[TB] row %0d op=%0d adr=%0d dat=%h rd=%h irq=%0d", i, tbl[i].op, tbl[i].adr, tbl[i].dat, rd, irq);
      end

      // Held strobe: ack every other cycle.
      @(negedge clk);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 16'h0002;
      acks = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (bus.wb_ack_o) acks++;
      end
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      check("held_stb_acks", 32'(acks), 32'd2);
      $display("[TB] held strobe acks=%0d", acks);

      // Blink: D5 toggles after 4th and 8th frame; D5 writes ignored.
      do_reset();
      for (int f = 1; f <= 8; f++) begin
         txn(2, 2'd0, 16'h0, 2'b00, 1'b1, rd);
         check($sformatf("blink_f%0d", f), 32'(vtcsr[5]), 32'((f >= 4 && f < 8) ? 1 : 0));
         $display("[TB] blink frame %0d d5=%0d", f, vtcsr[5]);
         if (f == 2) begin
            txn(1, 2'd1, 16'h0421, 2'b11, 1'b0, rd);
            check("blink_wr_d5", 32'(vtcsr), 32'h0401);
         end
      end

      // Beep: clears on 3rd frame; a restart gives 3 more frames.
      do_reset();
      txn(1, 2'd1, 16'h0411, 2'b11, 1'b0, rd);
      check("beep_set", 32'(vtcsr[4]), 32'd1);
      for (int f = 1; f <= 3; f++) begin
         txn(2, 2'd0, 16'h0, 2'b00, 1'b1, rd);
         check($sformatf("beep_f%0d", f), 32'(vtcsr[4]), 32'(f < 3 ? 1 : 0));
         $display("[TB] beep frame %0d d4=%0d", f, vtcsr[4]);
      end
      txn(1, 2'd1, 16'h0411, 2'b11, 1'b0, rd);
      repeat (2) txn(2, 2'd0, 16'h0, 2'b00, 1'b1, rd);
      txn(1, 2'd1, 16'h0411, 2'b11, 1'b0, rd);
      for (int f = 1; f <= 3; f++) begin
         txn(2, 2'd0, 16'h0, 2'b00, 1'b1, rd);
         check($sformatf("beep_re_f%0d", f), 32'(vtcsr[4]), 32'(f < 3 ? 1 : 0));
         $display("[TB] beep restart frame %0d d4=%0d", f, vtcsr[4]);
      end

      // Reset during a write's strobe cycle aborts it.
      txn(1, 2'd0, 16'h0123, 2'b11, 1'b0, rd);
      @(negedge clk);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
      bus.wb_adr_i = 16'h0000; bus.wb_dat_i = 16'h0456; bus.wb_sel_i = 2'b11;
      rst_n = 0;
      @(posedge clk); #1;
      check("rstx_ack", 32'(bus.wb_ack_o), 32'd0);
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      rst_n = 1;
      model_reset();
      @(posedge clk); #1;
      check("rstx_ack2", 32'(bus.wb_ack_o), 32'd0);
      check("rstx_cursor", 32'(cursor), 32'd0);
      check("rstx_vtcsr", 32'(vtcsr), 32'h0401);
      $display("[TB] reset mid-write cursor=%h vtcsr=%h", cursor, vtcsr);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         int op;
         logic [1:0] adr, sel;
         logic [15:0] dat;
         logic frm;
         op  = $urandom_range(0, 2);
         adr = 2'($urandom_range(0, 3));
         sel = 2'($urandom_range(0, 3));
         dat = 16'($urandom);
         frm = ($urandom_range(0, 2) == 0);
         txn(op, adr, dat, sel, frm, rd);
         $display("[TB] rnd %0d op=%0d adr=%0d dat=%h sel=%b frm=%0d rd=%h vtcsr=%h irq=%0d",
                  i, op, adr, dat, sel, frm, rd, vtcsr, irq);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
